opcode_dispatcher: RTL and testbench

- Sequencer between the host opcode stream and the GPU shape engines.
- Buffers incoming 96-bit opcodes in a small FIFO. Each opcode splits into shape[95:92], color[91:76] and opdata[75:0].
- Dispatches opcodes in order, one at a time, to the shape engine selected by the shape field, using a start/busy handshake.
- Drops NOPs and illegal shapes, counts completed operations, and reports errors.

---
 rtl/opcode_dispatcher.sv | 218 +++++++++++++++++++++
 tb/tb_opcode_dispatcher.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_dispatcher.sv
// opcode_dispatcher: sequencer between the host opcode stream and the shape engines.
//
// Buffers 96-bit opcodes {shape[95:92], color[91:76], opdata[75:0]} in a small FIFO.
// It dispatches them in order, one at a time, to the engine that the shape field selects.
// The engine handshake is a one-cycle start pulse followed by the engine's busy signal.
// NOPs (shape 0) and illegal shapes are dropped. Completed operations are counted.
//
// Ports:
//   clk, n_rst           clock (rising edge), asynchronous active-low reset
//   op_valid, op_data    host opcode stream; op_ready = FIFO not full
//   eng_busy, eng_start  per-engine busy inputs and one-hot start pulse
//   shape_out, color_out, opdata_out  fields of the current dispatched opcode
//   busy_out             FIFO non-empty or dispatch in progress
//   illegal_err          sticky error (illegal shape or ack timeout); clear_err clears it
//   ops_done             16-bit wrapping count of completed operations
module opcode_dispatcher #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   op_valid,
    input  logic [95:0]            op_data,
    output logic                   op_ready,
    input  logic [NUM_ENGINES-1:0] eng_busy,
    output logic [NUM_ENGINES-1:0] eng_start,
    output logic [3:0]             shape_out,
    output logic [15:0]            color_out,
    output logic [75:0]            opdata_out,
    output logic                   busy_out,
    output logic                   illegal_err,
    input  logic                   clear_err,
    output logic [15:0]            ops_done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TGT_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [95:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    // Dispatch context
    logic [TGT_W-1:0] target_q;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic [3:0]       shape_q;
    logic [15:0]      color_q;
    logic [75:0]      opdata_q;
    logic             illegal_err_q, illegal_err_d;
    logic [15:0]      ops_done_q;

    // Decoded head-of-FIFO fields
    logic [95:0]      head;
    logic [3:0]       head_shape;
    logic             shape_ok;
    logic [TGT_W-1:0] head_tgt;

    // Events from the next-state logic
    logic dispatch, drop_illegal, ack_timeout, op_complete;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Registered occupancy only: a same-cycle pop never reopens a full FIFO.
    assign op_ready   = !fifo_full;
    assign push       = op_valid && op_ready;

    assign head       = mem_q[rd_ptr_q];
    assign head_shape = head[95:92];
    assign shape_ok   = (head_shape != 4'd0) && (32'(head_shape) <= NUM_ENGINES);
    assign head_tgt   = TGT_W'(head_shape - 4'd1);

    // ------------------------------------------------------------------ FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= op_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------ FSM: state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // ------------------------------------------------------------------ FSM: next state
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        pop          = 1'b0;
        dispatch     = 1'b0;
        drop_illegal = 1'b0;
        ack_timeout  = 1'b0;
        op_complete  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_shape == 4'd0) begin
                        // NOP: dropped silently
                    end else if (!shape_ok) begin
                        drop_illegal = 1'b1;
                    end else begin
                        dispatch = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                // An engine already busy at issue time counts as acknowledged.
                if (eng_busy[target_q]) begin
                    state_d = StWaitDone;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                    if (tmo_d == TO_W'(ACK_TIMEOUT)) begin
                        ack_timeout = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (!eng_busy[target_q]) begin
                    op_complete = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ FSM: outputs
    always_comb begin
        eng_start = '0;
        if (state_q == StIssue) begin
            eng_start[target_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------ dispatch context
    // A set wins over a coincident clear.
    always_comb begin
        illegal_err_d = illegal_err_q;
        if (drop_illegal || ack_timeout) begin
            illegal_err_d = 1'b1;
        end else if (clear_err) begin
            illegal_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target_q      <= '0;
            shape_q       <= '0;
            color_q       <= '0;
            opdata_q      <= '0;
            illegal_err_q <= 1'b0;
            ops_done_q    <= '0;
        end else begin
            if (dispatch) begin
                target_q <= head_tgt;
                shape_q  <= head_shape;
                color_q  <= head[91:76];
                opdata_q <= head[75:0];
            end
            illegal_err_q <= illegal_err_d;
            if (op_complete) begin
                ops_done_q <= ops_done_q + 16'd1;
            end
        end
    end

    assign shape_out   = shape_q;
    assign color_out   = color_q;
    assign opdata_out  = opdata_q;
    assign illegal_err = illegal_err_q;
    assign ops_done    = ops_done_q;
    assign busy_out    = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_opcode_dispatcher.sv
module tb_opcode_dispatcher;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [95:0] op_data = '0;
    logic        op_ready;
    logic [3:0]  eng_busy;
    logic [3:0]  eng_start;
    logic [3:0]  shape_out;
    logic [15:0] color_out;
    logic [75:0] opdata_out;
    logic        busy_out;
    logic        illegal_err;
    logic        clear_err = 1'b0;
    logic [15:0] ops_done;

    opcode_dispatcher #(
        .FIFO_DEPTH (4),
        .NUM_ENGINES(4),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .op_valid   (op_valid),
        .op_data    (op_data),
        .op_ready   (op_ready),
        .eng_busy   (eng_busy),
        .eng_start  (eng_start),
        .shape_out  (shape_out),
        .color_out  (color_out),
        .opdata_out (opdata_out),
        .busy_out   (busy_out),
        .illegal_err(illegal_err),
        .clear_err  (clear_err),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int accepted = 0;

    // Reference model state
    logic [95:0] exp_q [$];
    logic [15:0] exp_ops = '0;
    logic        exp_err = 1'b0;

    // Engine models: busy for 'hold' cycles after a start, unless muted; 'stall' forces all busy.
    int  rem [4];
    bit  mute [4];
    bit  stall = 1'b0;
    int  hold = 3;

    always @(posedge clk or negedge n_rst) begin
        for (int k = 0; k < 4; k++) begin
            if (!n_rst) rem[k] <= 0;
            else if (eng_start[k] && !mute[k]) rem[k] <= hold;
            else if (rem[k] > 0) rem[k] <= rem[k] - 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) eng_busy[k] = stall || (rem[k] > 0);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: every start pulse is matched against the next expected dispatch.
    always @(negedge clk) begin : monitor
        logic [95:0] e;
        logic [3:0]  es;
        if (n_rst && eng_start != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_start: got start=%b, required no start", eng_start);
            end else begin
                e  = exp_q.pop_front();
                es = 4'b0001 << (e[95:92] - 4'd1);
                if ({eng_start, shape_out, color_out, opdata_out} === {es, e}) passes++;
                else $display("FAIL dispatch: got start=%b shape=%h color=%h opdata=%h, required start=%b shape=%h color=%h opdata=%h",
                              eng_start, shape_out, color_out, opdata_out,
                              es, e[95:92], e[91:76], e[75:0]);
                if (!mute[e[95:92] - 4'd1]) exp_ops = exp_ops + 16'd1;
            end
        end
    end

    function automatic logic [95:0] mk(input logic [3:0] s);
        return {s, 16'($urandom), 32'($urandom), 32'($urandom), 12'($urandom)};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_op(input logic [95:0] d);
        int n = 0;
        op_valid = 1'b1;
        op_data  = d;
        while (!op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            $display("FAIL push_timeout: got op_ready=0 for %0d cycles, required acceptance", n);
        end else begin
            @(posedge clk);
            accepted++;
            if (d[95:92] >= 4'd1 && d[95:92] <= 4'd4) exp_q.push_back(d);
            else if (d[95:92] > 4'd4) exp_err = 1'b1;
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy_out && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_out) begin
            checks++;
            $display("FAIL drain_timeout: got busy_out=1 after %0d cycles, required 0", n);
        end
        check("sb_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] d;
        for (int k = 0; k < 4; k++) mute[k] = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {eng_start, shape_out, color_out, opdata_out, busy_out, illegal_err, ops_done, op_ready},
              {4'b0, 4'h0, 16'h0, 76'h0, 1'b0, 1'b0, 16'h0, 1'b1});
        n_rst = 1'b1;
        @(negedge clk);

        // Single operation: latency, field hold, completion
        hold = 3;
        push_op({4'd1, 16'hF800, 76'h123});
        check("start_not_early", eng_start, 4'b0000);
        @(negedge clk);
        check("start_latency", eng_start, 4'b0001);
        drain();
        check("hold_fields", {color_out, opdata_out}, {16'hF800, 76'h123});
        check("ops_after_first", ops_done, 16'd1);
        check("busy_after_first", busy_out, 1'b0);

        // Backpressure with all engines stalled
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push_op(mk(4'($urandom_range(1, 4))));
        check("ready_low_full", op_ready, 1'b0);
        fork
            push_op(mk(4'($urandom_range(1, 4))));
        join_none
        repeat (5) @(negedge clk);
        check("held_while_full", 128'(accepted), 128'(6));
        stall = 1'b0;
        drain();
        wait fork;
        check("held_accepted", 128'(accepted), 128'(7));
        check("ops_after_stall", ops_done, exp_ops);

        // NOP, illegal, legal
        push_op(mk(4'd0));
        push_op(mk(4'hA));
        push_op(mk(4'd2));
        drain();
        check("err_after_illegal", illegal_err, 1'b1);
        clear_pulse();
        check("err_cleared", illegal_err, 1'b0);
        push_op(mk(4'hB));
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("set_beats_clear", illegal_err, 1'b1);
        drain();
        clear_pulse();
        check("err_cleared2", illegal_err, 1'b0);

        // Ack timeout on engine 2
        mute[2] = 1'b1;
        push_op(mk(4'd3));
        repeat (16) @(negedge clk);
        check("tmo_still_waiting", {busy_out, illegal_err}, {1'b1, 1'b0});
        @(negedge clk);
        check("tmo_expired", {busy_out, illegal_err}, {1'b0, 1'b1});
        check("tmo_ops_unchanged", ops_done, exp_ops);
        mute[2] = 1'b0;
        push_op(mk(4'd3));
        drain();
        check("after_tmo_ops", ops_done, exp_ops);
        clear_pulse();

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            hold = $urandom_range(1, 4);
            push_op(mk(4'($urandom_range(0, 6))));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain();
        check("rand_ops", ops_done, exp_ops);
        check("rand_err", illegal_err, exp_err);
        clear_pulse();

        // Counter wrap
        force dut.ops_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.ops_done_q;
        exp_ops = 16'hFFFF;
        check("preload_ffff", ops_done, 16'hFFFF);
        hold = 1;
        push_op(mk(4'd4));
        drain();
        check("wrap_zero", ops_done, 16'h0000);

        // Reset in WAIT_DONE with three opcodes queued
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_op(mk(4'($urandom_range(1, 4))));
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset",
              {eng_start, shape_out, color_out, opdata_out, busy_out, illegal_err, ops_done, op_ready},
              {4'b0, 4'h0, 16'h0, 76'h0, 1'b0, 1'b0, 16'h0, 1'b1});
        exp_q.delete();
        exp_ops = '0;
        exp_err = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", {busy_out, op_ready}, {1'b0, 1'b1});
        hold = 2;
        push_op(mk(4'd2));
        drain();
        check("post_reset_op", ops_done, 16'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
